// File: rtl/stack_cpu_controller.sv
// Multicycle control unit for the 8-bit stack computer: sequences fetch, decode
// and execute, and Moore-decodes every datapath and operand-stack strobe from the state.
module stack_cpu_controller #(
  parameter int OPW    = 3,
  parameter int STATEW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              mem_read,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              ir_write,
  output logic              mdr_load,
  output logic              pc_ld,
  output logic              pc_src,
  output logic              push,
  output logic              pop,
  output logic              tos,
  output logic              stack_src,
  output logic              a_load,
  output logic              b_load,
  output logic [1:0]        alu_op,
  output logic              instr_done,
  output logic [STATEW-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_POP_A    = 4'd2,
    S_LOAD_A   = 4'd3,
    S_LOAD_B   = 4'd4,
    S_ALU_PUSH = 4'd5,
    S_PUSH_RD  = 4'd6,
    S_PUSH_WR  = 4'd7,
    S_POP_ST   = 4'd8,
    S_POP_WR   = 4'd9,
    S_JMP      = 4'd10,
    S_JZ       = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_NOT  = OPW'(3);
  localparam logic [OPW-1:0] OP_PUSH = OPW'(4);
  localparam logic [OPW-1:0] OP_POP  = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(6);
  localparam logic [OPW-1:0] OP_JZ   = OPW'(7);

  state_t r_state;
  state_t w_next;
  logic   w_is_alu;
  logic   w_binary;

  // ADD/SUB/AND/NOT share the opcode half with bit 2 clear; NOT is the only unary one.
  assign w_is_alu = (opcode[OPW-1] == 1'b0);
  assign w_binary = w_is_alu && (opcode != OP_NOT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_alu)              w_next = S_POP_A;
        else if (opcode == OP_PUSH) w_next = S_PUSH_RD;
        else if (opcode == OP_POP)  w_next = S_POP_ST;
        else if (opcode == OP_JMP)  w_next = S_JMP;
        else                        w_next = S_JZ;
      end
      S_POP_A:   w_next = S_LOAD_A;
      S_LOAD_A:  w_next = (opcode == OP_NOT) ? S_ALU_PUSH : S_LOAD_B;
      S_LOAD_B:  w_next = S_ALU_PUSH;
      S_PUSH_RD: w_next = S_PUSH_WR;
      S_POP_ST:  w_next = S_POP_WR;
      default:   w_next = S_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mdr_load   = 1'b0;
    pc_ld      = 1'b0;
    pc_src     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    tos        = 1'b0;
    stack_src  = 1'b0;
    a_load     = 1'b0;
    b_load     = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = 1'b1;
          pc_ld    = 1'b1;
        end
        S_DECODE: tos = 1'b1;
        S_POP_A:  pop = 1'b1;
        S_LOAD_A: begin
          a_load = 1'b1;
          pop    = w_binary;
        end
        S_LOAD_B: b_load = 1'b1;
        S_ALU_PUSH: begin
          push       = 1'b1;
          stack_src  = 1'b1;
          alu_op     = opcode[1:0];
          instr_done = 1'b1;
        end
        S_PUSH_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          mdr_load = 1'b1;
        end
        S_PUSH_WR: begin
          push       = 1'b1;
          instr_done = 1'b1;
        end
        S_POP_ST: pop = 1'b1;
        S_POP_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = 1'b1;
        end
        S_JMP: begin
          pc_ld      = 1'b1;
          pc_src     = 1'b1;
          instr_done = 1'b1;
        end
        S_JZ: begin
          pc_ld      = zero;
          pc_src     = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? '0 : STATEW'(r_state);

endmodule

// File: doc/stack_cpu_controller.md
Name: stack_cpu_controller

Overview:
- Multicycle control unit for the 8-bit stack computer.
- Sequences fetch, decode and execute of each instruction, and drives the push/pop/tos strobes of the operand stack.
- Also drives the memory, IR, MDR, A/B operand registers, ALU and PC of the datapath.
- Sits directly upstream of the stack; consumes the opcode from IR and the zero flag of the stack top.

Parameters:
- OPW, 3, opcode width (IR[7:5]); fixed encoding below.
- STATEW, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  OPW  IR[7:5]. Encoding: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- zero  input  1  high when stack d_out == 0.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe (data = stack d_out).
- i_or_d  output  1  address mux: 0 = PC, 1 = IR[4:0].
- ir_write  output  1  load IR from memory data.
- mdr_load  output  1  load MDR from memory data.
- pc_ld  output  1  PC load enable.
- pc_src  output  1  PC mux: 0 = PC+1, 1 = IR[4:0].
- push  output  1  stack push strobe.
- pop  output  1  stack pop strobe.
- tos  output  1  stack top-of-stack read strobe.
- stack_src  output  1  stack d_in mux: 0 = MDR, 1 = ALU result.
- a_load  output  1  load A from stack d_out.
- b_load  output  1  load B from stack d_out.
- alu_op  output  2  00 ADD (A+B), 01 SUB (A-B), 10 AND, 11 NOT (~A).
- instr_done  output  1  one-cycle pulse in the last state of each instruction.
- state  output  STATEW  current state, for debug.

Behaviour:
- State register: asynchronous clear to FETCH on rst; advances on posedge clk.
- Outputs are Moore-decoded from state; every output not listed for a state is 0.
- While rst is high, all control outputs are forced 0 and state reads 0.
- State encodings and actions:
  - FETCH (0): mem_read, i_or_d=0, ir_write, pc_ld, pc_src=0 -> DECODE.
  - DECODE (1): tos. Next state by opcode:
    - ADD/SUB/AND/NOT -> POP_A
    - PUSH -> PUSH_RD
    - POP -> POP_ST
    - JMP -> JMP
    - JZ -> JZ
  - POP_A (2): pop (first operand to stack d_out) -> LOAD_A.
  - LOAD_A (3): a_load. Pop additionally asserted only for ADD/SUB/AND. NOT -> ALU_PUSH; others -> LOAD_B.
  - LOAD_B (4): b_load -> ALU_PUSH.
  - ALU_PUSH (5): push, stack_src=1, alu_op=opcode[1:0], instr_done -> FETCH.
  - PUSH_RD (6): mem_read, i_or_d=1, mdr_load -> PUSH_WR.
  - PUSH_WR (7): push, stack_src=0, instr_done -> FETCH.
  - POP_ST (8): pop -> POP_WR.
  - POP_WR (9): mem_write, i_or_d=1, instr_done -> FETCH.
  - JMP (10): pc_ld, pc_src=1, instr_done -> FETCH.
  - JZ (11): pc_src=1, pc_ld = zero, instr_done -> FETCH. JZ does not pop.
- alu_op is 00 in every state except ALU_PUSH.
- Unused encodings 12-15 -> FETCH on the next edge, all outputs 0.
- Cycles per instruction (FETCH to instr_done inclusive):
  - ADD/SUB/AND 6; NOT 5; PUSH 4; POP 4; JMP 3; JZ 3.
- push and pop are never asserted in the same cycle.
- The stack's own empty/full wrap is not checked here; program correctness is the software's responsibility.
- A reset asserted mid-instruction abandons that instruction; the first post-reset edge enters DECODE from FETCH.
- opcode is sampled only in DECODE, LOAD_A and ALU_PUSH. IR is stable over those states because ir_write occurs only in FETCH.

Test Plan:
- Reset: assert rst at state 7 -> state=0 immediately and all outputs 0. Deassert -> one cycle of FETCH (mem_read=1, ir_write=1, pc_ld=1), then DECODE with tos=1.
- ADD (opcode=000) -> states 0,1,2,3,4,5. pop=1 in states 2 and 3; a_load in 3; b_load in 4; push=1, stack_src=1, alu_op=00, instr_done=1 in 5. Back to 0.
- NOT (opcode=011) -> states 0,1,2,3,5. Pop in 3 is 0; b_load never asserted; alu_op=11 in 5. Total 5 cycles.
- PUSH (100) then POP (101) -> PUSH: 0,1,6 (mem_read, i_or_d=1, mdr_load), 7 (push, stack_src=0). POP: 0,1,8 (pop), 9 (mem_write, i_or_d=1).
- JZ (111): zero=1 -> state 11 with pc_ld=1, pc_src=1. zero=0 -> pc_ld=0. Both cases return to 0 after 3 cycles with instr_done=1 exactly once.
- Back-to-back stream ADD, JMP, PUSH with random zero -> instr_done pulses every 6, 3, 4 cycles. Assertion: push&pop never 1 together; mem_read&mem_write never 1 together.
